// File: rtl/laser_pkg.sv
// Shared definitions for the laser pattern playback path.
// Holds the state encoding of the byte serializer and the default frame
// geometry (bit period, blanking gap, bytes per frame). The RAM controller
// sizes its frame storage from the same defaults, so they live here rather
// than in either module.
package laser_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP,
    DONE  = ST_DONE
  } state_t;

  localparam int DEFAULT_BIT_CYCLES  = 4;
  localparam int DEFAULT_GAP_CYCLES  = 2;
  localparam int DEFAULT_FRAME_BYTES = 16;

  // Width of a counter that must hold values 0..max_value. A zero-sized
  // range (e.g. no blanking gap) still gets one bit so the register exists.
  function automatic int counter_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/laser_bit_timer.sv
// Reloadable down-counter used to time one bit period or one blanking gap.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : reload the counter with CYCLES-1 (takes priority)
//   enable     : count down while high
//   tick       : one-cycle pulse in the last cycle of the period
//                (enable high and counter at zero)
module laser_bit_timer
  import laser_pkg::*;
#(
  parameter int CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic tick
);

  localparam int W = counter_width(CYCLES);
  // A period of CYCLES cycles is counted as CYCLES-1 down to 0.
  localparam logic [W-1:0] RELOAD = (CYCLES > 0) ? W'(CYCLES - 1) : '0;

  logic [W-1:0] count;

  // Counter parks at zero instead of wrapping; the owner reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tick = enable && (count == '0);

endmodule

// File: rtl/laser_byte_serializer.sv
// Fetches pattern bytes from the RAM controller over a req/in_valid
// handshake and plays each one MSB-first on the laser modulation line,
// holding every bit BIT_CYCLES cycles and blanking GAP_CYCLES cycles
// between bytes. One run pulse plays FRAME_BYTES bytes, then pulses done.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   run        : start-of-frame strobe, only honoured when idle
//   in         : pattern byte from the RAM controller
//   in_valid   : in holds a valid byte
//   req        : asking for the next byte
//   laser      : laser on/off modulation
//   busy       : a frame is in progress
//   done       : one-cycle pulse at the end of a frame
module laser_byte_serializer
  import laser_pkg::*;
#(
  parameter int BIT_CYCLES  = DEFAULT_BIT_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       req,
  output logic       laser,
  output logic       busy,
  output logic       done
);

  localparam int BYTE_W = counter_width(FRAME_BYTES);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);

  state_t state;
  state_t next_state;

  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;

  logic bit_load, bit_en, bit_tick;
  logic gap_load, gap_en, gap_tick;
  logic latch, shift, byte_clr, byte_inc;

  laser_bit_timer #(.CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (bit_load),
    .enable (bit_en),
    .tick   (bit_tick)
  );

  laser_bit_timer #(.CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (gap_load),
    .enable (gap_en),
    .tick   (gap_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req        = 1'b0;
    laser      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    bit_load   = 1'b0;
    bit_en     = 1'b0;
    gap_load   = 1'b0;
    gap_en     = 1'b0;
    latch      = 1'b0;
    shift      = 1'b0;
    byte_clr   = 1'b0;
    byte_inc   = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (run) begin
          byte_clr   = 1'b1;
          next_state = FETCH;
        end
      end

      FETCH: begin
        req = 1'b1;
        if (in_valid) begin
          latch      = 1'b1;
          bit_load   = 1'b1;
          next_state = SHIFT;
        end
      end

      SHIFT: begin
        laser  = shreg[7];
        bit_en = 1'b1;
        if (bit_tick) begin
          if (bit_cnt != 3'd7) begin
            // Next bit: move it into the MSB and restart the bit period.
            shift    = 1'b1;
            bit_load = 1'b1;
          end else if (byte_cnt == LAST_BYTE) begin
            next_state = DONE;
          end else if (GAP_CYCLES > 0) begin
            byte_inc   = 1'b1;
            gap_load   = 1'b1;
            next_state = GAP;
          end else begin
            byte_inc   = 1'b1;
            next_state = FETCH;
          end
        end
      end

      GAP: begin
        gap_en = 1'b1;
        if (gap_tick) begin
          next_state = FETCH;
        end
      end

      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end

      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  // The bit counter stops at 7 on the last bit and is cleared by the next
  // latch, so it never wraps mid-byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      if (byte_clr) begin
        byte_cnt <= '0;
      end else if (byte_inc) begin
        byte_cnt <= byte_cnt + BYTE_W'(1);
      end

      if (latch) begin
        shreg   <= in;
        bit_cnt <= '0;
      end else if (shift) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule
